// File: rtl/multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_pkg
// Brief   : Shared arithmetic definitions (FSM encoding, counter sizing).
// Rev     : 1.0  initial release
// ============================================================================
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } arith_state_t;

    // Counter must be able to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiplier_if.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_if
// Brief   : Operand/result handshake bundle for the sequential multiplier.
// Rev     : 1.0  initial release
// ============================================================================
interface multiplier_if #(
    parameter int C_WIDTH = 32
);
    logic [C_WIDTH-1:0] a;
    logic [C_WIDTH-1:0] b;
    logic               signed_cal;
    logic               trigger;
    logic [C_WIDTH-1:0] p_hi;
    logic [C_WIDTH-1:0] p_lo;
    logic               ready;
    logic               done;

    modport master (
        output a, b, signed_cal, trigger,
        input  p_hi, p_lo, ready, done
    );

    modport slave (
        input  a, b, signed_cal, trigger,
        output p_hi, p_lo, ready, done
    );
endinterface
`default_nettype wire

// File: rtl/multiplier_mul_adder.sv
`default_nettype none
// ============================================================================
// Module  : mul_adder
// Brief   : Partial-sum adder with carry-out; 2-bit lookahead groups or behavioural.
// Rev     : 1.0  initial release
// ============================================================================
module mul_adder #(
    parameter int C_WIDTH = 32,
    parameter bit USE_CLA = 1'b1
) (
    input  wire logic [C_WIDTH-1:0] i_x,
    input  wire logic [C_WIDTH-1:0] i_y,
    output wire logic [C_WIDTH-1:0] o_sum,
    output wire logic               o_cout
);
    localparam int C_GRP = C_WIDTH / 2;

    generate
        if (USE_CLA) begin : g_cla
            wire [C_GRP:0] w_gc;
            assign w_gc[0] = 1'b0;

            for (genvar gi = 0; gi < C_GRP; gi++) begin : g_grp
                wire w_g0 = i_x[2*gi]   & i_y[2*gi];
                wire w_p0 = i_x[2*gi]   ^ i_y[2*gi];
                wire w_g1 = i_x[2*gi+1] & i_y[2*gi+1];
                wire w_p1 = i_x[2*gi+1] ^ i_y[2*gi+1];
                wire w_c1 = w_g0 | (w_p0 & w_gc[gi]);

                // Group carry-out computed directly from the group carry-in.
                assign w_gc[gi+1]    = w_g1 | (w_p1 & w_g0) | (w_p1 & w_p0 & w_gc[gi]);
                assign o_sum[2*gi]   = w_p0 ^ w_gc[gi];
                assign o_sum[2*gi+1] = w_p1 ^ w_c1;
            end

            assign o_cout = w_gc[C_GRP];
        end else begin : g_beh
            assign {o_cout, o_sum} = {1'b0, i_x} + {1'b0, i_y};
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module  : multiplier
// Brief   : Sequential shift-add multiplier, signed/unsigned, C_WIDTH+3 cycles.
// Rev     : 1.0  initial release
// ============================================================================
module multiplier
    import multiplier_pkg::*;
#(
    parameter int C_WIDTH = 32,
    parameter bit USE_CLA = 1'b1
) (
    input  wire logic   ctl_clk,
    input  wire logic   reset,
    multiplier_if.slave bus
);
    localparam int                 C_CNT_W    = cnt_width(C_WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    arith_state_t           state_q,  state_d;
    logic [C_CNT_W-1:0]     cnt_q,    cnt_d;
    logic [C_WIDTH-1:0]     mcand_q,  mcand_d;
    logic [C_WIDTH-1:0]     mplier_q, mplier_d;
    logic                   sign_q,   sign_d;
    logic [2*C_WIDTH-1:0]   acc_q,    acc_d;
    logic [C_WIDTH-1:0]     p_hi_q,   p_hi_d;
    logic [C_WIDTH-1:0]     p_lo_q,   p_lo_d;
    logic                   done_q,   done_d;
    logic                   ready_q,  ready_d;

    logic [C_WIDTH-1:0]     w_addend;
    logic [C_WIDTH-1:0]     w_sum;
    logic                   w_cout;
    logic [2*C_WIDTH-1:0]   w_prod;

    assign w_addend = mplier_q[0] ? mcand_q : '0;

    mul_adder #(
        .C_WIDTH (C_WIDTH),
        .USE_CLA (USE_CLA)
    ) u_adder (
        .i_x    (acc_q[2*C_WIDTH-1:C_WIDTH]),
        .i_y    (w_addend),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_prod = sign_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.trigger) begin
                    // Magnitudes fit in C_WIDTH unsigned bits, including -2^(C_WIDTH-1).
                    mcand_d  = (bus.signed_cal && bus.a[C_WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
                    mplier_d = (bus.signed_cal && bus.b[C_WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
                    sign_d   = bus.signed_cal & (bus.a[C_WIDTH-1] ^ bus.b[C_WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q == C_CNT_LAST) begin
                    state_d = SIGN;
                end else begin
                    acc_d    = {w_cout, w_sum, acc_q[C_WIDTH-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + C_CNT_ONE;
                end
            end
            SIGN: begin
                p_hi_d  = w_prod[2*C_WIDTH-1:C_WIDTH];
                p_lo_d  = w_prod[C_WIDTH-1:0];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == DONE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge ctl_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.p_hi  = p_hi_q;
    assign bus.p_lo  = p_lo_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;
endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : tb_multiplier
// Brief   : Directed-vector self-checking bench for the sequential multiplier.
// Rev     : 1.0  initial release
// ============================================================================
module tb_multiplier;
    localparam int C_WIDTH = 32;

    logic ctl_clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [63:0] prev_p;

    multiplier_if #(.C_WIDTH(C_WIDTH)) bus ();

    multiplier #(
        .C_WIDTH (C_WIDTH),
        .USE_CLA (1'b1)
    ) dut (
        .ctl_clk (ctl_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial begin
        ctl_clk = 1'b0;
        forever #5 ctl_clk = ~ctl_clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one operation from idle and check latency, busy flag, held outputs and result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp, input logic inject);
        int n;
        bus.a          = a;
        bus.b          = b;
        bus.signed_cal = sgn;
        bus.trigger    = 1'b1;
        @(posedge ctl_clk);
        #1;
        bus.trigger = 1'b0;
        bus.a       = ~a;
        bus.b       = b ^ 32'h5A5A_0F0F;
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge ctl_clk);
            #1;
            n++;
            bus.trigger = inject && (n == 10);
            if (n == 5) begin
                chk({tag, "_busy"}, {63'd0, bus.ready}, 64'd0);
                chk({tag, "_hold"}, {bus.p_hi, bus.p_lo}, prev_p);
            end
        end
        bus.trigger = 1'b0;
        chk({tag, "_lat"}, 64'(n), 64'd34);
        chk({tag, "_prod"}, {bus.p_hi, bus.p_lo}, exp);
        chk({tag, "_rdy"}, {63'd0, bus.ready}, 64'd1);
        @(posedge ctl_clk);
        #1;
        chk({tag, "_pulse"}, {63'd0, bus.done}, 64'd0);
        prev_p = exp;
    endtask

    initial begin
        int n;
        int dones;
        logic [31:0] bb_a [3];
        logic [31:0] bb_b [3];
        logic [63:0] bb_p [3];

        n_vec = 0;
        n_err = 0;
        prev_p = 64'd0;
        reset = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.signed_cal = 1'b0;
        bus.trigger = 1'b0;
        #1;
        chk("rst_p", {bus.p_hi, bus.p_lo}, 64'd0);
        chk("rst_rdy", {63'd0, bus.ready}, 64'd1);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        #21;
        reset = 1'b0;

        run_op("umax",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("s5m3",  32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run_op("sext",  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        run_op("uext",  32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 1'b0);
        run_op("sm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
        run_op("u7x6",  32'h0000_0007, 32'h0000_0006, 1'b0, 64'h0000_0000_0000_002A, 1'b0);
        run_op("busy",  32'h0000_1234, 32'h0000_0010, 1'b0, 64'h0000_0000_0001_2340, 1'b1);
        run_op("zero",  32'h0000_0000, 32'h0000_1234, 1'b0, 64'h0000_0000_0000_0000, 1'b0);
        run_op("s12x7", 32'hFFFF_FFF4, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFAC, 1'b0);

        // Abort mid-calculation with an asynchronous reset
        bus.a = 32'h0000_00FF;
        bus.b = 32'h0000_0003;
        bus.signed_cal = 1'b0;
        bus.trigger = 1'b1;
        @(posedge ctl_clk);
        #1;
        bus.trigger = 1'b0;
        repeat (12) @(posedge ctl_clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rdy", {63'd0, bus.ready}, 64'd1);
        chk("arst_p", {bus.p_hi, bus.p_lo}, 64'd0);
        @(posedge ctl_clk);
        #3;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ctl_clk);
            #1;
            if (bus.done) dones++;
        end
        chk("arst_nodone", 64'(dones), 64'd0);
        prev_p = 64'd0;
        run_op("post_rst", 32'h0000_00FF, 32'h0000_0003, 1'b0, 64'h0000_0000_0000_02FD, 1'b0);

        // Back-to-back with trigger held high
        bb_a[0] = 32'h0000_0003; bb_b[0] = 32'h0000_0007; bb_p[0] = 64'h0000_0000_0000_0015;
        bb_a[1] = 32'h0000_FFFF; bb_b[1] = 32'h0001_0001; bb_p[1] = 64'h0000_0000_FFFF_FFFF;
        bb_a[2] = 32'h8000_0000; bb_b[2] = 32'h0000_0002; bb_p[2] = 64'h0000_0001_0000_0000;
        bus.signed_cal = 1'b0;
        bus.a = bb_a[0];
        bus.b = bb_b[0];
        bus.trigger = 1'b1;
        @(posedge ctl_clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                bus.a = bb_a[k+1];
                bus.b = bb_b[k+1];
            end else begin
                bus.trigger = 1'b0;
            end
            n = 0;
            while (!bus.done && n < 100) begin
                @(posedge ctl_clk);
                #1;
                n++;
            end
            chk($sformatf("b2b%0d_lat", k), 64'(n), 64'd34);
            chk($sformatf("b2b%0d_prod", k), {bus.p_hi, bus.p_lo}, bb_p[k]);
            chk($sformatf("b2b%0d_rdy", k), {63'd0, bus.ready}, 64'd1);
            @(posedge ctl_clk);
            #1;
            chk($sformatf("b2b%0d_pulse", k), {63'd0, bus.done}, 64'd0);
        end
        bus.trigger = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, operand width in bits (even, >= 4).
REQ-002 SHALL have parameter USE_CLA, default 1: 1 = carry-lookahead partial-sum adder, 0 = behavioural adder.
REQ-003 SHALL have port ctl_clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port a, input, C_WIDTH: multiplicand.
REQ-006 SHALL have port b, input, C_WIDTH: multiplier.
REQ-007 SHALL have port signed_cal, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port trigger, input, 1: start request, level-sampled.
REQ-009 SHALL have port p_hi, output, C_WIDTH: upper half of product.
REQ-010 SHALL have port p_lo, output, C_WIDTH: lower half of product.
REQ-011 SHALL have port ready, output, 1: idle, able to accept trigger.
REQ-012 SHALL have port done, output, 1: one-cycle pulse, product valid.

Function
REQ-013 SHALL use FSM states IDLE, CALC, SIGN, DONE.
REQ-014 IDLE: ready=1; trigger=1 on a rising edge SHALL latch a, b, signed_cal, clear the accumulator and the iteration counter, and go to CALC.
REQ-015 Latch: signed_cal=1 SHALL store |a| and |b| as C_WIDTH-bit unsigned magnitudes (|-2^(C_WIDTH-1)| = 2^(C_WIDTH-1)) and store result sign = a[MSB] XOR b[MSB]; signed_cal=0 SHALL store the raw operands with sign 0.
REQ-016 CALC: each cycle SHALL add the multiplicand to the upper accumulator half when the current multiplier LSB is 1, then shift the 2*C_WIDTH+1-bit {carry, accumulator} right by 1; exactly C_WIDTH cycles, then go to SIGN.
REQ-017 SIGN: one cycle; SHALL two's-complement negate the 2*C_WIDTH-bit product when the stored sign is 1, register it to p_hi/p_lo, and go to DONE.
REQ-018 DONE: one cycle; done=1, ready=1; then go to IDLE.
REQ-019 Latency: trigger sampled at edge T SHALL give done=1 and valid p_hi/p_lo in the cycle after edge T+C_WIDTH+2 (34 edges for C_WIDTH=32).
REQ-020 ready SHALL be 0 in CALC and SIGN, and 1 in IDLE and DONE.
REQ-021 trigger=1 in DONE SHALL start a new operation (back-to-back, same as IDLE); trigger in CALC/SIGN SHALL be ignored.
REQ-022 Operand changes after the latch edge SHALL NOT affect the running result.
REQ-023 p_hi/p_lo SHALL hold the last product until the next SIGN state; they SHALL NOT change during CALC.
REQ-024 A zero operand SHALL still take the full latency and give product 0.

Reset
REQ-025 reset=1 SHALL force IDLE immediately and asynchronously, independent of ctl_clk.
REQ-026 Reset values: p_hi=0, p_lo=0, done=0, ready=1, accumulator/counter/operand registers=0.
REQ-027 Reset during CALC/SIGN/DONE SHALL abort the operation without producing a done pulse.
REQ-028 The first trigger SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 FSM state encoding and the iteration-counter width function (clog2(C_WIDTH+1)) SHALL live in the shared arithmetic package that the divider also uses.
REQ-030 The partial-sum adder SHALL be one sub-module, mul_adder, C_WIDTH-bit with carry-out; USE_CLA selects its implementation.
REQ-031 The data path SHALL contain no combinational multiply operator.

Verification (C_WIDTH=32)
REQ-032 Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, signed_cal=0 -> p_hi=0xFFFFFFFE, p_lo=0x00000001; done 34 edges after trigger.
REQ-033 Signed: a=0x00000005, b=0xFFFFFFFD, signed_cal=1 -> p_hi=0xFFFFFFFF, p_lo=0xFFFFFFF1.
REQ-034 Signed extreme: a=b=0x80000000, signed_cal=1 -> p_hi=0x40000000, p_lo=0x00000000; same operands unsigned -> 0x40000000/0x00000000.
REQ-035 Busy trigger: start 0x1234*0x10, pulse trigger with new operands 10 cycles later -> ignored; result p_lo=0x00012340, p_hi=0; then a zero operand -> product 0 after full latency.
REQ-036 Reset mid-op: assert reset 12 cycles into CALC -> immediately ready=1, outputs 0, no done pulse; new trigger after release completes normally.
REQ-037 Back-to-back: trigger held high continuously -> done pulses every 35 cycles with ready=1 in DONE; each result correct.
